// File: rtl/dual_port_ram_core.sv
// dual_port_ram_core
// Simple dual-port storage block with per-location "written" tracking.
//
// The write port stores data_in at wr_address and marks the location as
// written. The read port returns the stored word one cycle after the request.
// A read of a location that has not been written since reset returns zero
// and raises rd_err, so the reader can tell it apart from real data.
//
// Ports:
//   clock      - single clock; all state updates on the rising edge
//   reset      - asynchronous, active-high
//   data_in    - write data                       [DATA_WIDTH]
//   wr_address - write location                   [ADDR_WIDTH]
//   write      - write enable
//   rd_address - read location                    [ADDR_WIDTH]
//   read       - read enable
//   data_out   - registered read data             [DATA_WIDTH]
//   rd_valid   - one-cycle pulse: data_out updated by this read
//   rd_err     - qualifies rd_valid: location never written since reset
//   wr_count   - distinct locations written since reset [ADDR_WIDTH+1]
module dual_port_ram_core #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   wr_count
);

    // Storage has no reset; the bitmap is what hides stale contents.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      written_q;
    logic [ADDR_WIDTH:0]   wr_count_q;
    logic [ADDR_WIDTH:0]   wr_count_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic                  rd_valid_q;
    logic                  rd_valid_d;
    logic                  rd_err_q;
    logic                  rd_err_d;
    logic                  collide_s;

    // Same-edge write and read of one location: the read sees the new data.
    assign collide_s = write && read && (wr_address == rd_address);

    // Storage array write port (no reset so it maps onto a RAM macro).
    always_ff @(posedge clock) begin
        if (write) begin
            mem_q[wr_address] <= data_in;
        end
    end

    // Written-location bitmap, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            written_q <= '0;
        end else if (write) begin
            written_q[wr_address] <= 1'b1;
        end
    end

    // Next-state for the count of distinct written locations. Only a first
    // write to a location counts, so the count cannot exceed DEPTH.
    always_comb begin
        wr_count_d = wr_count_q;
        if (write && !written_q[wr_address]) begin
            wr_count_d = wr_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Next-state for the read result registers.
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        if (read) begin
            rd_valid_d = 1'b1;
            if (collide_s) begin
                data_out_d = data_in;
                rd_err_d   = 1'b0;
            end else if (written_q[rd_address]) begin
                data_out_d = mem_q[rd_address];
                rd_err_d   = 1'b0;
            end else begin
                data_out_d = '0;
                rd_err_d   = 1'b1;
            end
        end else begin
            data_out_d = data_out_q;
            rd_valid_d = 1'b0;
            rd_err_d   = 1'b0;
        end
    end

    // Count and read-result registers; reset discards any read in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_count_q <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            wr_count_q <= wr_count_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_count = wr_count_q;

endmodule
